// File: rtl/abc_pkg.sv
// Shared definitions for the {a,b,c} -> select encoder.
// Contents:
//   CODE_S0/CODE_S1/CODE_S2 : the three legal decoder code words
//   abc_entry_t             : packed {s, err} result carried through the queue
//   abc_encode              : maps a code word to its result entry
package abc_pkg;

  localparam logic [2:0] CODE_S0 = 3'b011;
  localparam logic [2:0] CODE_S1 = 3'b000;
  localparam logic [2:0] CODE_S2 = 3'b111;

  typedef struct packed {
    logic [1:0] s;
    logic       err;
  } abc_entry_t;

  // Any word that is not one of the three legal codes maps to s=0 with err set.
  // Select 1 is encoded as 2'b01, so 2'b11 never appears on the output.
  function automatic abc_entry_t abc_encode(input logic [2:0] code);
    abc_entry_t e;
    e.s   = 2'b00;
    e.err = 1'b1;
    case (code)
      CODE_S0: begin e.s = 2'b00; e.err = 1'b0; end
      CODE_S1: begin e.s = 2'b01; e.err = 1'b0; end
      CODE_S2: begin e.s = 2'b10; e.err = 1'b0; end
      default: begin e.s = 2'b00; e.err = 1'b1; end
    endcase
    return e;
  endfunction

endpackage

// File: rtl/abc_fifo2.sv
// Two-entry in-order queue of abc_entry_t.
// Ports:
//   clk, aresetn : clock, asynchronous active-low reset
//   push, push_data : write request and entry (ignored when full)
//   pop             : read request (ignored when empty)
//   full, empty     : decoded from the registered occupancy only
//   head            : oldest entry, forced to zero when empty
module abc_fifo2
  import abc_pkg::*;
(
  input  logic       clk,
  input  logic       aresetn,
  input  logic       push,
  input  abc_entry_t push_data,
  input  logic       pop,
  output logic       full,
  output logic       empty,
  output abc_entry_t head
);

  logic [1:0] occ;
  logic       wr_ptr;
  logic       rd_ptr;
  abc_entry_t mem [2];
  logic       push_ok;
  logic       pop_ok;

  assign full    = (occ == 2'd2);
  assign empty   = (occ == 2'd0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign head    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      occ    <= 2'd0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= ~wr_ptr;
      if (pop_ok)  rd_ptr <= ~rd_ptr;
      // Simultaneous push and pop leaves occupancy unchanged.
      case ({push_ok, pop_ok})
        2'b10:   occ <= occ + 2'd1;
        2'b01:   occ <= occ - 2'd1;
        default: occ <= occ;
      endcase
    end
  end

  // Storage carries data only; validity comes from occ, so no reset is needed.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/abc_encoder.sv
// Registered inverse of the 2-bit select decoder.
// Ports:
//   clk, aresetn           : clock, asynchronous active-low reset
//   in_valid/in_ready      : input handshake for code word {a,b,c}
//   out_valid/out_ready    : output handshake for the queue head
//   out_s, out_err         : head entry (zero when queue empty)
//   err_clr                : synchronous clear of the illegal-word counter
//   err_cnt                : saturating count of accepted illegal words
module abc_encoder
  import abc_pkg::*;
#(
  parameter int ERR_W = 8
) (
  input  logic             clk,
  input  logic             aresetn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             a,
  input  logic             b,
  input  logic             c,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [1:0]       out_s,
  output logic             out_err,
  input  logic             err_clr,
  output logic [ERR_W-1:0] err_cnt
);

  function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
    return (v == {ERR_W{1'b1}}) ? v : v + ERR_W'(1);
  endfunction

  abc_entry_t entry_p0;
  abc_entry_t head_p1;
  logic       vld_p0;
  logic       bad_p0;
  logic       full;
  logic       empty;

  // Stage 0: map the incoming word and qualify it with the handshake.
  assign entry_p0 = abc_encode({a, b, c});
  assign vld_p0   = in_valid && in_ready;
  assign bad_p0   = vld_p0 && entry_p0.err;

  // Stage 1: two-entry queue; in_ready depends only on registered occupancy.
  abc_fifo2 u_fifo (
    .clk       (clk),
    .aresetn   (aresetn),
    .push      (vld_p0),
    .push_data (entry_p0),
    .pop       (out_ready),
    .full      (full),
    .empty     (empty),
    .head      (head_p1)
  );

  assign in_ready  = !full;
  assign out_valid = !empty;
  assign out_s     = head_p1.s;
  assign out_err   = head_p1.err;

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      err_cnt <= '0;
    end else if (err_clr) begin
      // A clear that coincides with an illegal accept counts that word.
      err_cnt <= ERR_W'(bad_p0);
    end else if (bad_p0) begin
      err_cnt <= sat_inc(err_cnt);
    end
  end

endmodule

// File: tb/tb_abc_encoder.sv
module tb_abc_encoder;

  logic       clk = 1'b0;
  logic       aresetn;
  logic       in_valid;
  logic       in_ready;
  logic       a, b, c;
  logic       out_valid;
  logic       out_ready;
  logic [1:0] out_s;
  logic       out_err;
  logic       err_clr;
  logic [7:0] err_cnt;

  int vectors    = 0;
  int miscompares = 0;

  logic [2:0] exp_q[$];
  int         mcnt;

  always #5 clk = ~clk;

  abc_encoder #(.ERR_W(8)) dut (
    .clk       (clk),
    .aresetn   (aresetn),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .c         (c),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_s     (out_s),
    .out_err   (out_err),
    .err_clr   (err_clr),
    .err_cnt   (err_cnt)
  );

  // Reference mapping written from the code table: {s,err}.
  function automatic logic [2:0] ref_map(input logic [2:0] code);
    case (code)
      3'b000:  return 3'b01_0;
      3'b011:  return 3'b00_0;
      3'b111:  return 3'b10_0;
      default: return 3'b00_1;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    logic [2:0] hd;
    hd = (exp_q.size() > 0) ? exp_q[0] : 3'b000;
    check({tag, ".in_ready"},  32'(in_ready),  32'(exp_q.size() < 2));
    check({tag, ".out_valid"}, 32'(out_valid), 32'(exp_q.size() > 0));
    check({tag, ".out_s"},     32'(out_s),     32'(hd[2:1]));
    check({tag, ".out_err"},   32'(out_err),   32'(hd[0]));
    check({tag, ".err_cnt"},   32'(err_cnt),   32'(mcnt));
  endtask

  // Drive one cycle of stimulus, advance the model across the edge, then check.
  task automatic step(input string tag, input logic v, input logic [2:0] code,
                      input logic ordy, input logic clr);
    logic acc, pop;
    logic [2:0] e;
    in_valid  = v;
    {a, b, c} = code;
    out_ready = ordy;
    err_clr   = clr;
    acc = aresetn && v && (exp_q.size() < 2);
    pop = aresetn && ordy && (exp_q.size() > 0);
    e   = ref_map(code);
    @(posedge clk);
    #1;
    if (!aresetn) begin
      exp_q.delete();
      mcnt = 0;
    end else begin
      if (pop) void'(exp_q.pop_front());
      if (acc) exp_q.push_back(e);
      if (clr) mcnt = (acc && e[0]) ? 1 : 0;
      else if (acc && e[0] && mcnt < 255) mcnt++;
    end
    check_all(tag);
  endtask

  initial begin
    logic [2:0] legal [3];
    logic [2:0] illegal [5];
    legal   = '{3'b011, 3'b000, 3'b111};
    illegal = '{3'b001, 3'b010, 3'b100, 3'b101, 3'b110};
    mcnt = 0;
    aresetn = 1'b0;
    in_valid = 1'b0; {a, b, c} = 3'b000; out_ready = 1'b0; err_clr = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    check_all("reset");
    aresetn = 1'b1;

    // Legal sweep with downstream always ready.
    foreach (legal[i]) step("legal", 1'b1, legal[i], 1'b1, 1'b0);
    step("legal_drain", 1'b0, 3'b000, 1'b1, 1'b0);

    // Illegal sweep.
    foreach (illegal[i]) step("illegal", 1'b1, illegal[i], 1'b1, 1'b0);
    step("illegal_drain", 1'b0, 3'b000, 1'b1, 1'b0);
    check("illegal_total", 32'(err_cnt), 32'd5);

    // Backpressure: three words offered with out_ready low, then release.
    step("bp_w0", 1'b1, 3'b000, 1'b0, 1'b0);
    step("bp_w1", 1'b1, 3'b111, 1'b0, 1'b0);
    step("bp_w2", 1'b1, 3'b011, 1'b0, 1'b0);
    check("bp_full_ready", 32'(in_ready), 32'd0);
    step("bp_pop1", 1'b1, 3'b011, 1'b1, 1'b0);
    step("bp_pop2", 1'b0, 3'b000, 1'b1, 1'b0);
    step("bp_pop3", 1'b0, 3'b000, 1'b1, 1'b0);
    step("bp_idle", 1'b0, 3'b000, 1'b1, 1'b0);

    // Saturation and clear.
    step("clr0", 1'b0, 3'b000, 1'b1, 1'b1);
    for (int i = 0; i < 260; i++) step("sat", 1'b1, 3'b101, 1'b1, 1'b0);
    check("sat_value", 32'(err_cnt), 32'd255);
    step("clr_alone", 1'b0, 3'b000, 1'b1, 1'b1);
    check("clr_alone_value", 32'(err_cnt), 32'd0);
    step("sat_refill", 1'b1, 3'b010, 1'b1, 1'b0);
    step("clr_with_bad", 1'b1, 3'b110, 1'b1, 1'b1);
    check("clr_with_bad_value", 32'(err_cnt), 32'd1);
    step("clr_drain", 1'b0, 3'b000, 1'b1, 1'b0);

    // Simultaneous push/pop at occupancy 1.
    step("pp_fill", 1'b1, 3'b000, 1'b0, 1'b0);
    step("pp_both1", 1'b1, 3'b111, 1'b1, 1'b0);
    step("pp_both2", 1'b1, 3'b011, 1'b1, 1'b0);
    step("pp_drain", 1'b0, 3'b000, 1'b1, 1'b0);

    // Randomized traffic.
    for (int i = 0; i < 400; i++)
      step("rand", 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
           1'($urandom_range(0, 1)), ($urandom_range(0, 15) == 0));
    step("rand_drain1", 1'b0, 3'b000, 1'b1, 1'b0);
    step("rand_drain2", 1'b0, 3'b000, 1'b1, 1'b1);

    // Mid-operation reset with a full queue and err_cnt = 3.
    step("mr_a", 1'b1, 3'b001, 1'b1, 1'b0);
    step("mr_b", 1'b1, 3'b010, 1'b1, 1'b0);
    step("mr_c", 1'b1, 3'b100, 1'b0, 1'b0);
    check("mr_cnt3", 32'(err_cnt), 32'd3);
    #2;
    aresetn = 1'b0;
    #1;
    exp_q.delete();
    mcnt = 0;
    check_all("mr_async");
    step("mr_held", 1'b1, 3'b000, 1'b1, 1'b0);
    aresetn = 1'b1;
    step("mr_first", 1'b1, 3'b111, 1'b0, 1'b0);
    check("mr_first_alone", 32'(exp_q.size() == 1 && out_valid && in_ready), 32'd1);
    step("mr_drain", 1'b0, 3'b000, 1'b1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
